// File: rtl/vera_top_if.sv
// Host strobe-bus control group: chip select, read/write strobes and register offset.
// The 8-bit data bus is bidirectional and stays a plain inout on the top level.
interface vera_top_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [4:0] a;

  modport master (output cs_n, rd_n, wr_n, a);
  modport slave  (input  cs_n, rd_n, wr_n, a);
endinterface

// File: rtl/vera_top.sv
// VERA host register front end: strobe-bus decode, two auto-incrementing VRAM
// ports with prefetch latches over 128 KiB of video RAM, and a byte-wide SD SPI master.
module vera_top (
  input  logic       clk25,
  input  logic       reset_n,
  vera_top_if.slave  extbus,
  inout  wire  [7:0] extbus_d,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ssel_n_sd
);
  localparam int unsigned AW         = 17;
  localparam int unsigned DW         = 8;
  localparam int unsigned RW         = 5;
  localparam int unsigned VRAM_DEPTH = 1 << AW;

  localparam logic [RW-1:0] REG_ADDR_L   = 5'h00;
  localparam logic [RW-1:0] REG_ADDR_M   = 5'h01;
  localparam logic [RW-1:0] REG_ADDR_H   = 5'h02;
  localparam logic [RW-1:0] REG_DATA0    = 5'h03;
  localparam logic [RW-1:0] REG_DATA1    = 5'h04;
  localparam logic [RW-1:0] REG_CTRL     = 5'h05;
  localparam logic [RW-1:0] REG_SPI_DATA = 5'h1E;
  localparam logic [RW-1:0] REG_SPI_CTRL = 5'h1F;

  typedef enum logic {SPI_IDLE, SPI_RUN} spi_state_e;

  function automatic logic [AW-1:0] step_of(input logic [3:0] idx);
    case (idx)
      4'd0:    step_of = 17'd0;
      4'd1:    step_of = 17'd1;
      4'd2:    step_of = 17'd2;
      4'd3:    step_of = 17'd4;
      4'd4:    step_of = 17'd8;
      4'd5:    step_of = 17'd16;
      4'd6:    step_of = 17'd32;
      4'd7:    step_of = 17'd64;
      4'd8:    step_of = 17'd128;
      4'd9:    step_of = 17'd256;
      4'd10:   step_of = 17'd512;
      4'd11:   step_of = 17'd40;
      4'd12:   step_of = 17'd80;
      4'd13:   step_of = 17'd160;
      4'd14:   step_of = 17'd320;
      default: step_of = 17'd640;
    endcase
  endfunction

  // Strobe synchronizers; a/d are sampled alongside stage 1 and captured while the strobe is seen asserted
  logic [1:0]    cs_sync_q, rd_sync_q, wr_sync_q;
  logic [RW-1:0] a_smp_q, cap_a_q;
  logic [DW-1:0] d_smp_q, cap_d_q;
  logic          wr_act_q, rd_act_q;
  logic          wr_act, rd_act, wr_evt, rd_evt;

  assign wr_act = !(cs_sync_q[1] || wr_sync_q[1]);
  assign rd_act = !(cs_sync_q[1] || rd_sync_q[1]);
  assign wr_evt = wr_act_q && !wr_act;
  assign rd_evt = rd_act_q && !rd_act;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q <= 2'b11;
      rd_sync_q <= 2'b11;
      wr_sync_q <= 2'b11;
      a_smp_q   <= '0;
      d_smp_q   <= '0;
      cap_a_q   <= '0;
      cap_d_q   <= '0;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
    end else begin
      cs_sync_q <= {cs_sync_q[0], extbus.cs_n};
      rd_sync_q <= {rd_sync_q[0], extbus.rd_n};
      wr_sync_q <= {wr_sync_q[0], extbus.wr_n};
      a_smp_q   <= extbus.a;
      d_smp_q   <= extbus_d;
      if (!cs_sync_q[0] && !(wr_sync_q[0] && rd_sync_q[0])) begin
        cap_a_q <= a_smp_q;
        cap_d_q <= d_smp_q;
      end
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
    end
  end

  logic            op_v_q, op_v_d, op_wr_q, op_wr_d;
  logic [RW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_d_q, op_d_d;
  logic [AW-1:0]   addr_q [2];
  logic [AW-1:0]   addr_d [2];
  logic [3:0]      incr_q [2];
  logic [3:0]      incr_d [2];
  logic            decr_q [2];
  logic            decr_d [2];
  logic [DW-1:0]   latch_q [2];
  logic [DW-1:0]   latch_d [2];
  logic            sel_q, sel_d;
  logic            fetch_v_q, fetch_v_d, fetch_port_q, fetch_port_d;
  logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
  logic            ld_v_q, ld_v_d, ld_port_q, ld_port_d;
  logic [DW-1:0]   ram_q;
  logic            ram_we, soft_rst, op_port, op_other, spi_start;
  logic [AW-1:0]   ram_waddr;
  spi_state_e      spi_state_q, spi_state_d;
  logic [4:0]      spi_div_q, spi_div_d, spi_div_max;
  logic [3:0]      spi_half_q, spi_half_d;
  logic            spi_sck_q, spi_sck_d, spi_mosi_q, spi_mosi_d;
  logic [DW-1:0]   spi_tx_q, spi_tx_d, spi_rx_q, spi_rx_d, spi_data_q, spi_data_d;
  logic            spi_ssel_n_q, spi_ssel_n_d, spi_slow_q, spi_slow_d;

  assign op_port     = (op_a_q == REG_DATA1);
  assign op_other    = !op_port;
  assign ram_waddr   = addr_q[op_port];
  assign spi_div_max = spi_slow_q ? 5'd31 : 5'd0;
  assign spi_start   = op_v_q && op_wr_q && (op_a_q == REG_SPI_DATA) && (spi_state_q == SPI_IDLE);

  // Side-effect pipeline: op captured (cycle 0) -> execute (1) -> VRAM read (2) -> latch load (3)
  always_comb begin
    op_v_d       = wr_evt || rd_evt;
    op_wr_d      = wr_evt;
    op_a_d       = cap_a_q;
    op_d_d       = cap_d_q;
    addr_d       = addr_q;
    incr_d       = incr_q;
    decr_d       = decr_q;
    latch_d      = latch_q;
    sel_d        = sel_q;
    ram_we       = 1'b0;
    soft_rst     = 1'b0;
    fetch_v_d    = 1'b0;
    fetch_port_d = fetch_port_q;
    fetch_addr_d = fetch_addr_q;
    ld_v_d       = fetch_v_q;
    ld_port_d    = fetch_port_q;
    spi_state_d  = spi_state_q;
    spi_div_d    = spi_div_q;
    spi_half_d   = spi_half_q;
    spi_sck_d    = spi_sck_q;
    spi_mosi_d   = spi_mosi_q;
    spi_tx_d     = spi_tx_q;
    spi_rx_d     = spi_rx_q;
    spi_data_d   = spi_data_q;
    spi_ssel_n_d = spi_ssel_n_q;
    spi_slow_d   = spi_slow_q;

    if (ld_v_q) latch_d[ld_port_q] = ram_q;

    if (op_v_q) begin
      case (op_a_q)
        REG_ADDR_L: if (op_wr_q) begin
          addr_d[sel_q][7:0] = op_d_q;
          fetch_v_d = 1'b1; fetch_port_d = sel_q;
        end
        REG_ADDR_M: if (op_wr_q) begin
          addr_d[sel_q][15:8] = op_d_q;
          fetch_v_d = 1'b1; fetch_port_d = sel_q;
        end
        REG_ADDR_H: if (op_wr_q) begin
          addr_d[sel_q][16] = op_d_q[0];
          decr_d[sel_q]     = op_d_q[3];
          incr_d[sel_q]     = op_d_q[7:4];
          fetch_v_d = 1'b1; fetch_port_d = sel_q;
        end
        REG_DATA0, REG_DATA1: begin
          if (op_wr_q) begin
            ram_we = 1'b1;
            // Keep the other port coherent when it points at the byte being written
            if (addr_q[op_other] == addr_q[op_port]) latch_d[op_other] = op_d_q;
          end
          addr_d[op_port] = decr_q[op_port] ? addr_q[op_port] - step_of(incr_q[op_port])
                                            : addr_q[op_port] + step_of(incr_q[op_port]);
          fetch_v_d = 1'b1; fetch_port_d = op_port;
        end
        REG_CTRL: if (op_wr_q) begin
          if (op_d_q[7]) soft_rst = 1'b1;
          else           sel_d    = op_d_q[0];
        end
        REG_SPI_CTRL: if (op_wr_q) begin
          spi_ssel_n_d = !op_d_q[0];
          spi_slow_d   = op_d_q[1];
        end
        default: ;
      endcase
      fetch_addr_d = addr_d[fetch_port_d];
    end

    // SPI mode 0: sample MISO on rising SCK, shift MOSI on falling SCK
    case (spi_state_q)
      SPI_IDLE: if (spi_start) begin
        spi_state_d = SPI_RUN;
        spi_tx_d    = op_d_q;
        spi_mosi_d  = op_d_q[7];
        spi_div_d   = '0;
        spi_half_d  = '0;
        spi_sck_d   = 1'b0;
      end
      SPI_RUN: if (spi_div_q == spi_div_max) begin
        spi_div_d  = '0;
        spi_half_d = spi_half_q + 4'd1;
        if (!spi_sck_q) begin
          spi_sck_d = 1'b1;
          spi_rx_d  = {spi_rx_q[6:0], spi_miso};
        end else begin
          spi_sck_d  = 1'b0;
          spi_tx_d   = {spi_tx_q[6:0], 1'b0};
          spi_mosi_d = spi_tx_q[6];
        end
        if (spi_half_q == 4'd15) begin
          spi_state_d = SPI_IDLE;
          spi_data_d  = spi_rx_q;
        end
      end else begin
        spi_div_d = spi_div_q + 5'd1;
      end
      default: spi_state_d = SPI_IDLE;
    endcase

    if (soft_rst) begin
      addr_d       = '{default: '0};
      incr_d       = '{default: '0};
      decr_d       = '{default: 1'b0};
      latch_d      = '{default: '0};
      sel_d        = 1'b0;
      fetch_v_d    = 1'b0;
      ld_v_d       = 1'b0;
      spi_state_d  = SPI_IDLE;
      spi_div_d    = '0;
      spi_half_d   = '0;
      spi_sck_d    = 1'b0;
      spi_mosi_d   = 1'b0;
      spi_tx_d     = '0;
      spi_rx_d     = '0;
      spi_data_d   = '0;
      spi_ssel_n_d = 1'b1;
      spi_slow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      op_v_q       <= 1'b0;
      op_wr_q      <= 1'b0;
      op_a_q       <= '0;
      op_d_q       <= '0;
      addr_q       <= '{default: '0};
      incr_q       <= '{default: '0};
      decr_q       <= '{default: 1'b0};
      latch_q      <= '{default: '0};
      sel_q        <= 1'b0;
      fetch_v_q    <= 1'b0;
      fetch_port_q <= 1'b0;
      fetch_addr_q <= '0;
      ld_v_q       <= 1'b0;
      ld_port_q    <= 1'b0;
      spi_state_q  <= SPI_IDLE;
      spi_div_q    <= '0;
      spi_half_q   <= '0;
      spi_sck_q    <= 1'b0;
      spi_mosi_q   <= 1'b0;
      spi_tx_q     <= '0;
      spi_rx_q     <= '0;
      spi_data_q   <= '0;
      spi_ssel_n_q <= 1'b1;
      spi_slow_q   <= 1'b0;
    end else begin
      op_v_q       <= op_v_d;
      op_wr_q      <= op_wr_d;
      op_a_q       <= op_a_d;
      op_d_q       <= op_d_d;
      addr_q       <= addr_d;
      incr_q       <= incr_d;
      decr_q       <= decr_d;
      latch_q      <= latch_d;
      sel_q        <= sel_d;
      fetch_v_q    <= fetch_v_d;
      fetch_port_q <= fetch_port_d;
      fetch_addr_q <= fetch_addr_d;
      ld_v_q       <= ld_v_d;
      ld_port_q    <= ld_port_d;
      spi_state_q  <= spi_state_d;
      spi_div_q    <= spi_div_d;
      spi_half_q   <= spi_half_d;
      spi_sck_q    <= spi_sck_d;
      spi_mosi_q   <= spi_mosi_d;
      spi_tx_q     <= spi_tx_d;
      spi_rx_q     <= spi_rx_d;
      spi_data_q   <= spi_data_d;
      spi_ssel_n_q <= spi_ssel_n_d;
      spi_slow_q   <= spi_slow_d;
    end
  end

  // Video RAM: contents survive both resets
  logic [DW-1:0] vram_mem [VRAM_DEPTH];
  always_ff @(posedge clk25) begin
    if (ram_we) vram_mem[ram_waddr] <= op_d_q;
    ram_q <= vram_mem[fetch_addr_q];
  end

  logic [DW-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (extbus.a)
      REG_ADDR_L:   rd_data = addr_q[sel_q][7:0];
      REG_ADDR_M:   rd_data = addr_q[sel_q][15:8];
      REG_ADDR_H:   rd_data = {incr_q[sel_q], decr_q[sel_q], 2'b00, addr_q[sel_q][16]};
      REG_DATA0:    rd_data = latch_q[0];
      REG_DATA1:    rd_data = latch_q[1];
      REG_CTRL:     rd_data = {7'b0, sel_q};
      REG_SPI_DATA: rd_data = spi_data_q;
      REG_SPI_CTRL: rd_data = {spi_state_q == SPI_RUN, 5'b0, spi_slow_q, !spi_ssel_n_q};
      default:      ;
    endcase
  end

  assign extbus_d      = (!extbus.cs_n && !extbus.rd_n) ? rd_data : {DW{1'bz}};
  assign spi_sck       = spi_sck_q;
  assign spi_mosi      = spi_mosi_q;
  assign spi_ssel_n_sd = spi_ssel_n_q;
endmodule

// File: tb/tb_vera_top.sv
// Scoreboard bench for vera_top: register reads and SPI MOSI bits are queued as
// expectations when stimulus is issued and checked when the DUT presents them.
module tb_vera_top;
  logic       clk25 = 1'b0;
  logic       reset_n;
  logic [7:0] tb_d;
  logic       tb_oe;
  wire  [7:0] extbus_d;
  logic       spi_sck, spi_mosi, spi_miso, spi_ssel_n_sd;

  vera_top_if extbus();

  assign extbus_d = tb_oe ? tb_d : 8'hzz;

  vera_top dut (
    .clk25         (clk25),
    .reset_n       (reset_n),
    .extbus        (extbus),
    .extbus_d      (extbus_d),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_ssel_n_sd (spi_ssel_n_sd)
  );

  always #20 clk25 = ~clk25;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic       mosi_exp_q[$];
  int         cyc = 0;
  int         nrise = 0;
  int         t_first = 0;
  int         t_last = 0;
  logic       sck_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk25);
    extbus.a = a; tb_d = d; tb_oe = 1'b1;
    extbus.cs_n = 1'b0; extbus.wr_n = 1'b0;
    repeat (4) @(negedge clk25);
    extbus.cs_n = 1'b1; extbus.wr_n = 1'b1;
    @(negedge clk25);
    tb_oe = 1'b0;
    repeat (6) @(negedge clk25);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk25);
    extbus.a = a; extbus.cs_n = 1'b0; extbus.rd_n = 1'b0;
    repeat (3) @(negedge clk25);
    got = extbus_d;
    extbus.cs_n = 1'b1; extbus.rd_n = 1'b1;
    check(tag_q.pop_front(), {24'h0, got}, {24'h0, exp_q.pop_front()});
    repeat (7) @(negedge clk25);
  endtask

  task automatic push_spi(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mosi_exp_q.push_back(b[i]);
  endtask

  // MOSI must be stable and correct on every rising SCK
  always @(negedge clk25) begin
    cyc++;
    if (spi_sck && !sck_prev) begin
      if (nrise == 0) t_first = cyc;
      nrise++;
      if (mosi_exp_q.size() == 0) check("mosi_unexpected", 32'(mosi_exp_q.size()), 32'd1);
      else check("mosi_bit", {31'b0, spi_mosi}, {31'b0, mosi_exp_q.pop_front()});
    end
    if (!spi_sck && sck_prev) t_last = cyc;
    sck_prev = spi_sck;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; tb_oe = 1'b0; tb_d = '0; spi_miso = 1'b0;
    extbus.cs_n = 1'b1; extbus.rd_n = 1'b1; extbus.wr_n = 1'b1; extbus.a = '0;
    repeat (3) @(negedge clk25);
    check("rst_ssel", {31'b0, spi_ssel_n_sd}, 32'd1);
    check("rst_sck",  {31'b0, spi_sck}, 32'd0);
    check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk25);
    rd(5'h00, 8'h00, "rst_addr_l");
    rd(5'h02, 8'h00, "rst_addr_h");
    rd(5'h03, 8'h00, "rst_data0");
    rd(5'h05, 8'h00, "rst_ctrl");
    rd(5'h1F, 8'h00, "rst_spi_ctrl");
    rd(5'h1E, 8'h00, "rst_spi_data");
    rd(5'h06, 8'h00, "unmapped");

    // Port 1 sequential write then read-back
    wr(5'h05, 8'h01);
    wr(5'h00, 8'h00); wr(5'h01, 8'h40); wr(5'h02, 8'h10);
    wr(5'h04, 8'hA1); wr(5'h04, 8'hA2); wr(5'h04, 8'hA3); wr(5'h04, 8'hA4);
    wr(5'h00, 8'h00);
    rd(5'h04, 8'hA1, "p1_rd0");
    rd(5'h04, 8'hA2, "p1_rd1");
    rd(5'h04, 8'hA3, "p1_rd2");
    rd(5'h04, 8'hA4, "p1_rd3");
    rd(5'h00, 8'h04, "p1_addr_l");
    rd(5'h01, 8'h40, "p1_addr_m");
    rd(5'h02, 8'h10, "p1_addr_h");

    // 17-bit wrap on port 0
    wr(5'h05, 8'h00);
    wr(5'h00, 8'hFF); wr(5'h01, 8'hFF); wr(5'h02, 8'h11);
    wr(5'h03, 8'h55);
    rd(5'h00, 8'h00, "wrap_addr_l");
    rd(5'h01, 8'h00, "wrap_addr_m");
    rd(5'h02, 8'h10, "wrap_addr_h");
    wr(5'h02, 8'h01); wr(5'h00, 8'hFF); wr(5'h01, 8'hFF);
    rd(5'h03, 8'h55, "wrap_data");

    // Decrement by 16
    wr(5'h02, 8'h58); wr(5'h00, 8'h00); wr(5'h01, 8'h01);
    wr(5'h03, 8'h11); wr(5'h03, 8'h22);
    rd(5'h00, 8'hE0, "decr_addr_l");
    rd(5'h01, 8'h00, "decr_addr_m");
    rd(5'h02, 8'h58, "decr_addr_h");
    wr(5'h02, 8'h00); wr(5'h00, 8'h00); wr(5'h01, 8'h01);
    rd(5'h03, 8'h11, "decr_at_100");
    wr(5'h00, 8'hF0); wr(5'h01, 8'h00);
    rd(5'h03, 8'h22, "decr_at_0f0");

    // Cross-port latch coherence
    wr(5'h05, 8'h01);
    wr(5'h02, 8'h00); wr(5'h00, 8'h00); wr(5'h01, 8'h20);
    wr(5'h05, 8'h00);
    wr(5'h00, 8'h00); wr(5'h01, 8'h20);
    wr(5'h03, 8'h3C);
    rd(5'h04, 8'h3C, "coh_data1");
    rd(5'h03, 8'h3C, "coh_data0");

    // Slow SPI, MISO low
    wr(5'h1F, 8'h03);
    check("slow_ssel", {31'b0, spi_ssel_n_sd}, 32'd0);
    spi_miso = 1'b0;
    push_spi(8'h3C);
    nrise = 0;
    wr(5'h1E, 8'h3C);
    repeat (600) @(negedge clk25);
    check("slow_nrise", 32'(nrise), 32'd8);
    check("slow_span", 32'(t_last - t_first), 32'd480);
    rd(5'h1F, 8'h03, "slow_ctrl_done");
    rd(5'h1E, 8'h00, "slow_rx");

    // Fast SPI, MISO high
    wr(5'h1F, 8'h01);
    spi_miso = 1'b1;
    push_spi(8'hA5);
    nrise = 0;
    wr(5'h1E, 8'hA5);
    rd(5'h1F, 8'h81, "fast_busy");
    repeat (30) @(negedge clk25);
    check("fast_nrise", 32'(nrise), 32'd8);
    check("fast_span", 32'(t_last - t_first), 32'd15);
    rd(5'h1F, 8'h01, "fast_ctrl_done");
    rd(5'h1E, 8'hFF, "fast_rx");
    check("fast_ssel", {31'b0, spi_ssel_n_sd}, 32'd0);

    // Soft reset
    wr(5'h05, 8'h01);
    wr(5'h05, 8'h80);
    rd(5'h05, 8'h00, "srst_ctrl");
    rd(5'h00, 8'h00, "srst_addr_l");
    rd(5'h01, 8'h00, "srst_addr_m");
    rd(5'h02, 8'h00, "srst_addr_h");
    rd(5'h03, 8'h00, "srst_data0");
    rd(5'h1F, 8'h00, "srst_spi_ctrl");
    rd(5'h1E, 8'h00, "srst_spi_data");
    check("srst_ssel", {31'b0, spi_ssel_n_sd}, 32'd1);
    wr(5'h05, 8'h01);
    rd(5'h01, 8'h00, "srst_p1_addr_m");
    rd(5'h04, 8'h00, "srst_data1");

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    check("mosi_drain", 32'(mosi_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vera_top.md
# vera_top

Host-bus register front end for the video/SPI controller: decodes a 5-bit register window (host range $9F20–$9F3F) on an asynchronous 6502-style strobe bus, runs two auto-incrementing VRAM address/data ports over an internal 128 KiB video RAM, and hosts a byte-wide SPI master for the SD card. It is the top-level integration point between the host CPU and video memory; display generation is out of scope.

## Interface
- No parameters.
- clk25  in  1  25 MHz system clock; all internal logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- extbus_cs_n  in  1  chip select, active low, asynchronous to clk25.
- extbus_rd_n  in  1  read strobe, active low.
- extbus_wr_n  in  1  write strobe, active low.
- extbus_a  in  5  register offset.
- extbus_d  inout  8  data bus; driven only while cs_n=0 and rd_n=0, else Z.
- spi_sck  out  1  SPI clock, idle low (mode 0).
- spi_mosi  out  1  SPI data out, MSB first.
- spi_miso  in  1  SPI data in.
- spi_ssel_n_sd  out  1  SD chip select, active low.

## Operation
- Register map (unlisted offsets read $00, writes ignored):
  - $00 ADDRx_L, $01 ADDRx_M: address bits [7:0], [15:8] of port selected by ADDRSEL.
  - $02 ADDRx_H: bit0 = address bit16, bit3 = DECR, bits[7:4] = INCR index.
  - $03 DATA0, $04 DATA1: VRAM byte at ADDR0 / ADDR1.
  - $05 CTRL: bit0 ADDRSEL (R/W); bit7 write-1 = soft reset (reads 0).
  - $1E SPI_DATA: write starts transfer; read returns last received byte.
  - $1F SPI_CTRL: bit0 select (spi_ssel_n_sd = !bit0), bit1 slow, bit7 busy (RO).
- INCR index → step: 0,1,2,4,8,16,32,64,128,256,512,40,80,160,320,640. DECR=1 subtracts. Address arithmetic is 17-bit, wraps modulo 2^17.
- Each port owns a prefetch latch. Reads of DATAx return the latch combinationally.
- DATAx write: store byte at ADDRx, then ADDRx ± step, then refetch latch from new address.
- DATAx read: at end of strobe, ADDRx ± step, refetch latch.
- Write to any ADDRx byte: update field, refetch latch for that port.
- Write to DATAx where the other port addresses the same location: the other port's latch also updates.
- Soft reset: all registers and latches return to reset values; VRAM untouched.
- SPI: 8 bits, MSB first; MOSI changes on falling SCK, MISO sampled on rising SCK. Fast SCK = clk25/2, slow = clk25/64. busy=1 from write until last bit done; SPI_DATA writes while busy are ignored.

## Timing
- Bus inputs are asynchronous: cs_n/rd_n/wr_n pass a 2-flop synchronizer; a/d sampled every clk25 edge. Write commits on deassertion edge of synchronized (cs_n|wr_n), using a/d sampled while strobe was last asserted (data valid ≥25 ns before strobe end, address held 10 ns after).
- Read side-effects fire on deassertion edge of synchronized (cs_n|rd_n); read data path is combinational from registers/latches.
- Side-effect pipeline: detect (cycle 0), VRAM write + address update (cycle 1), VRAM read at new address (cycle 2), latch loaded (cycle 3). A new access must be accepted every 3 clk25 cycles (back-to-back 8 MHz bus cycles, 125 ns).
- Reset values: all addresses/INCR/DECR 0, ADDRSEL 0, latches $00, SPI_DATA $00, spi_sck 0, spi_mosi 0, spi_ssel_n_sd 1, busy 0, extbus_d Z.
- reset_n mid-transfer aborts SPI and pending bus side-effects immediately.

## Test plan
- Write CTRL=$01, ADDR1 = $00/$40/$10, DATA1 = $A1,$A2,$A3,$A4; reload ADDR1 = $04000 incr 1; read DATA1 ×4 → $A1,$A2,$A3,$A4, ADDR1_L reads $04.
- ADDRSEL=0, ADDR0=$1FFFF INCR=1, write DATA0 $55 → ADDR0 wraps to $00000; read back at $1FFFF = $55.
- ADDR0_H=$58 (DECR, step 16) at $00100: two DATA0 writes land at $00100,$000F0; address ends $000E0.
- Port 0 and port 1 both at $02000; write DATA0=$3C → DATA1 read returns $3C without address rewrite.
- SPI_CTRL=$01, SPI_DATA=$A5 with miso=1 → mosi shifts 1,0,1,0,0,1,0,1, 16 fast-mode clk25 cycles, busy then clears, SPI_DATA reads $FF, ssel_n=0.
- CTRL=$80 after setup → all registers read $00, SPI_CTRL reads $00, ssel_n=1.
